intxn_timed_ctrl: RTL
=====================

// Module: intxn_timed_ctrl
// PURPOSE
//  Parametrised successor to the highway/farm-road light controller. Keeps NS highway green until an EW car or
//  pedestrian request is pending and a minimum NS green has elapsed. It then sequences the lights with:
//   - configurable phase times;
//   - all-red clearance phases;
//   - EW green extension while a car is present;
//   - a pedestrian walk lamp.
//  Sits between the sensor/button synchronisers and the lamp drivers.
// PARAMETERS
//  TICKS_PER_SEC  50_000_000  clk cycles per 1 s timebase tick (>=1)
//  SEC_W          4           width of phase-seconds counter; every T_* below must be < 2**SEC_W
//  T_MIN_GREEN_NS 4           minimum NS green, s (>=0)
//  T_YELLOW_NS    1           NS yellow, s (>=1)
//  T_ALL_RED      1           each all-red clearance, s (>=1)
//  T_GREEN_EW     4           base EW green, s (>=1)
//  T_GREEN_EW_MAX 8           EW green cap incl. extension, s (>=T_GREEN_EW)
//  T_YELLOW_EW    2           EW yellow, s (>=1)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  car          in   1  EW car sensor, level, already synchronised
//  ped_req      in   1  EW pedestrian button, pulse or level, already synchronised
//  lights       out  6  {ns_g,ns_y,ns_r,ew_g,ew_y,ew_r}
//  walk         out  1  pedestrian walk lamp
//  state_o      out  3  current state code (debug)
//  req_pending  out  1  car_pend | ped_pend
// BEHAVIOUR
//  States: GNS=0, YNS=1, RED1=2, GEW=3, YEW=4, RED2=5. Codes 6/7 go to GNS on the next edge.
//  Moore outputs decoded from the state register, no added latency:
//   - GNS 100001, YNS 010001, RED1/RED2 001001, GEW 001100, YEW 001010; illegal code 001001.
//  Reset (sync, wins over all) sets:
//   - state GNS, lights 100001;
//   - prescaler=0, sec=0;
//   - car_pend=0, ped_pend=0, walk_active=0;
//   - walk=0, req_pending=0.
//  Timebase: on every state change, prescaler<=0 and sec<=0.
//   - Otherwise prescaler increments; tick when prescaler==TICKS_PER_SEC-1, then prescaler<=0 and sec<=sec+1.
//   - sec saturates at 2**SEC_W-1.
//   - A phase of T s therefore lasts exactly T*TICKS_PER_SEC cycles: exit on the tick edge where sec+1==T.
//  req = car | ped_req | car_pend | ped_pend (combinational).
//  GNS: -> YNS on the first edge with req=1 and sec>=T_MIN_GREEN_NS.
//   - A car arriving after min green moves the state to YNS on the same edge that samples it.
//  YNS -> RED1 after T_YELLOW_NS.  RED1 -> GEW after T_ALL_RED.
//  GEW: leaves to YEW on a tick edge when either condition holds:
//   - (sec+1>=T_GREEN_EW && car==0), or
//   - sec+1==T_GREEN_EW_MAX.
//   Otherwise GEW extends 1 s at a time.
//  YEW -> RED2 after T_YELLOW_EW.  RED2 -> GNS after T_ALL_RED.
//  Latches:
//   - car_pend is set by car in any state except GEW, and cleared on the GEW entry edge (clear wins).
//   - ped_pend is set by ped_req in any state.
//   - On GEW entry: walk_active<=ped_pend|ped_req and ped_pend<=0. A press during GEW re-latches for the next cycle.
//   - walk = walk_active & (state==GEW). walk_active clears on GEW exit.
//  Requests during YEW/RED2 are held, so NS receives its full minimum green before serving them.
//  Prescaler width is $clog2(TICKS_PER_SEC), minimum 1. TICKS_PER_SEC=1 gives a tick every cycle.
// TESTING (TICKS_PER_SEC=4, other parameters at default; cycles counted from reset release)
//  1 No car/ped for 200 cycles -> lights=100001, state_o=0, walk=0 throughout.
//  2 car 1-cycle pulse at cycle 2 -> GNS to cycle 16, then:
//     - YNS 4 cycles 010001, RED1 4 cycles 001001, GEW 16 cycles 001100, YEW 8 cycles 001010;
//     - RED2 4 cycles 001001, then 100001 and stays there.
//  3 car held high from cycle 0 -> GEW lasts 32 cycles (cap 8 s).
//     - Then, after RED2, GNS lasts exactly 16 cycles before YNS again.
//  4 ped_req pulse at cycle 5, car low -> walk=1 for exactly the 16 GEW cycles, 0 elsewhere. req_pending drops on GEW entry.
//  5 car at cycle 40 (sec already >=4) -> state_o=1 at cycle 41.
//  6 reset high for 1 cycle mid-GEW with car and ped pending -> next edge:
//     - lights=100001, walk=0, req_pending=0;
//     - with car low, GNS holds indefinitely.

Source files
------------

// File: rtl/intxn_timed_ctrl_if.sv
// Sensor/button inputs and lamp/debug outputs of the intersection controller.
// Slave modport is the controller side; master modport is the driving/observing side.
// Purely a signal bundle with no logic, latency or flow control.
interface intxn_timed_ctrl_if;
    logic       car;          // EW car sensor, level, synchronised
    logic       ped_req;      // EW pedestrian button, pulse or level, synchronised
    logic [5:0] lights;       // {ns_g,ns_y,ns_r,ew_g,ew_y,ew_r}
    logic       walk;         // pedestrian walk lamp
    logic [2:0] state_o;      // current state code
    logic       req_pending;  // car_pend | ped_pend

    modport slave  (input  car, ped_req, output lights, walk, state_o, req_pending);
    modport master (output car, ped_req, input  lights, walk, state_o, req_pending);
endinterface

// File: rtl/intxn_timed_ctrl.sv
// Highway/farm-road light controller with timed phases, all-red clearance, EW extension and walk lamp.
// Latency: Moore outputs decoded straight from the state register; inputs act on the next clk edge.
// Backpressure: none; inputs are levels/pulses, requests are latched until served.
// Ports: clk, reset (sync, active-high), bus.car/bus.ped_req in; bus.lights/walk/state_o/req_pending out.
module intxn_timed_ctrl #(
    parameter int TICKS_PER_SEC  = 50_000_000,
    parameter int SEC_W          = 4,
    parameter int T_MIN_GREEN_NS = 4,
    parameter int T_YELLOW_NS    = 1,
    parameter int T_ALL_RED      = 1,
    parameter int T_GREEN_EW     = 4,
    parameter int T_GREEN_EW_MAX = 8,
    parameter int T_YELLOW_EW    = 2
) (
    input  logic               clk,
    input  logic               reset,
    intxn_timed_ctrl_if.slave  bus
);

    localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [SEC_W-1:0] SEC_SAT = '1;

    // Phase times widened by one bit so they compare against sec+1 without wrap.
    localparam logic [SEC_W:0] T_MIN_W  = (SEC_W+1)'(T_MIN_GREEN_NS);
    localparam logic [SEC_W:0] T_YNS_W  = (SEC_W+1)'(T_YELLOW_NS);
    localparam logic [SEC_W:0] T_RED_W  = (SEC_W+1)'(T_ALL_RED);
    localparam logic [SEC_W:0] T_GEW_W  = (SEC_W+1)'(T_GREEN_EW);
    localparam logic [SEC_W:0] T_GMAX_W = (SEC_W+1)'(T_GREEN_EW_MAX);
    localparam logic [SEC_W:0] T_YEW_W  = (SEC_W+1)'(T_YELLOW_EW);

    typedef enum logic [2:0] {
        S_GNS  = 3'd0,
        S_YNS  = 3'd1,
        S_RED1 = 3'd2,
        S_GEW  = 3'd3,
        S_YEW  = 3'd4,
        S_RED2 = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic               car_pend_q, car_pend_d;
    logic               ped_pend_q, ped_pend_d;
    logic               walk_active_q, walk_active_d;

    logic               tick;
    logic [SEC_W:0]     sec_inc;
    logic [SEC_W:0]     sec_w;
    logic               req;
    logic               gew_entry;
    logic               gew_exit;
    logic [5:0]         lamp;

    assign tick    = (presc_q == PRE_MAX);
    assign sec_w   = {1'b0, sec_q};
    assign sec_inc = sec_w + 1'b1;
    assign req     = bus.car | bus.ped_req | car_pend_q | ped_pend_q;

    // Next state. Timed phases leave only on the tick edge that completes their last second.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_GNS:  if (req && (sec_w >= T_MIN_W))            state_d = S_YNS;
            S_YNS:  if (tick && (sec_inc == T_YNS_W))         state_d = S_RED1;
            S_RED1: if (tick && (sec_inc == T_RED_W))         state_d = S_GEW;
            S_GEW:  if (tick && (((sec_inc >= T_GEW_W) && !bus.car) ||
                                  (sec_inc == T_GMAX_W)))     state_d = S_YEW;
            S_YEW:  if (tick && (sec_inc == T_YEW_W))         state_d = S_RED2;
            S_RED2: if (tick && (sec_inc == T_RED_W))         state_d = S_GNS;
            default:                                          state_d = S_GNS;
        endcase
    end

    // Timebase restarts on every state change so each phase measures from its own entry edge.
    always_comb begin
        presc_d = presc_q + PRE_W'(1);
        sec_d   = sec_q;
        if (state_d != state_q) begin
            presc_d = '0;
            sec_d   = '0;
        end else if (tick) begin
            presc_d = '0;
            if (sec_q != SEC_SAT) begin
                sec_d = sec_q + SEC_W'(1);
            end
        end
    end

    assign gew_entry = (state_q != S_GEW) && (state_d == S_GEW);
    assign gew_exit  = (state_q == S_GEW) && (state_d != S_GEW);

    // Request latches. Clearing on GEW entry wins over a same-edge set; a press during GEW
    // is kept for the following EW cycle.
    always_comb begin
        car_pend_d    = car_pend_q;
        ped_pend_d    = ped_pend_q | bus.ped_req;
        walk_active_d = walk_active_q;
        if (gew_entry) begin
            car_pend_d    = 1'b0;
            ped_pend_d    = 1'b0;
            walk_active_d = ped_pend_q | bus.ped_req;
        end else begin
            if (bus.car && (state_q != S_GEW)) begin
                car_pend_d = 1'b1;
            end
            if (gew_exit) begin
                walk_active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_GNS;
            presc_q       <= '0;
            sec_q         <= '0;
            car_pend_q    <= 1'b0;
            ped_pend_q    <= 1'b0;
            walk_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            sec_q         <= sec_d;
            car_pend_q    <= car_pend_d;
            ped_pend_q    <= ped_pend_d;
            walk_active_q <= walk_active_d;
        end
    end

    // Lamp decode: {ns_g,ns_y,ns_r,ew_g,ew_y,ew_r}; any unknown code shows all-red.
    always_comb begin
        lamp = 6'b001001;
        case (state_q)
            S_GNS:   lamp = 6'b100001;
            S_YNS:   lamp = 6'b010001;
            S_GEW:   lamp = 6'b001100;
            S_YEW:   lamp = 6'b001010;
            default: lamp = 6'b001001;
        endcase
    end

    assign bus.lights      = lamp;
    assign bus.walk        = walk_active_q & (state_q == S_GEW);
    assign bus.state_o     = state_q;
    assign bus.req_pending = car_pend_q | ped_pend_q;

endmodule
